// File: rtl/drop_sequencer.sv
// Connect Four turn sequencer: one-hot column presses drive a falling-piece
// animation (DROP_TICKS cycles per row), then a 1-cycle commit into the board.
// Latency: press visible in DROP 2 cycles after the pin edge; no backpressure, presses while busy/over are dropped.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pins[COLS-1:0]        column buttons, bit k = column k
//   rd_col, rd_row        scan read address; rd_cell = board cell (00 when out of range)
//   anim_valid/col/row    position of the falling piece
//   player                side to move (0 = P1, 1 = P2)
//   busy                  high in DROP and COMMIT
//   reject                1-cycle pulse on a press into a full column
//   move_count, game_over pieces committed, board full
module drop_sequencer #(
  parameter int COLS       = 7,
  parameter int ROWS       = 6,
  parameter int DROP_TICKS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [COLS-1:0]                  pins,
  input  logic [$clog2(COLS)-1:0]          rd_col,
  input  logic [$clog2(ROWS)-1:0]          rd_row,
  output logic [1:0]                       rd_cell,
  output logic                             anim_valid,
  output logic [$clog2(COLS)-1:0]          anim_col,
  output logic [$clog2(ROWS)-1:0]          anim_row,
  output logic                             player,
  output logic                             busy,
  output logic                             reject,
  output logic [$clog2(ROWS*COLS+1)-1:0]   move_count,
  output logic                             game_over
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(ROWS * COLS + 1);
  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

  localparam logic [HW-1:0] FULL_H    = HW'(ROWS);
  localparam logic [RW-1:0] TOP_ROW   = RW'(ROWS - 1);
  localparam logic [MW-1:0] MAX_MOVES = MW'(ROWS * COLS);
  localparam logic [TW-1:0] LAST_TICK = TW'(DROP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DROP   = 2'd1,
    COMMIT = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] pins_q, pins_d;
  logic [COLS-1:0] pins_prev_q, pins_prev_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   target_q, target_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            anim_valid_q, anim_valid_d;
  logic            reject_q, reject_d;
  logic            player_q, player_d;
  logic [MW-1:0]   move_count_q, move_count_d;
  logic [1:0]      board_q [COLS][ROWS];
  logic [1:0]      board_d [COLS][ROWS];
  logic [HW-1:0]   height_q [COLS];
  logic [HW-1:0]   height_d [COLS];

  logic            press_evt;
  logic [CW-1:0]   press_col;

  // A press is a clean 0 -> one-hot transition of the registered pins, so a
  // held button or a multi-button chord never produces a second event.
  always_comb begin
    press_evt = $onehot(pins_q) && (pins_prev_q == '0);
    press_col = '0;
    for (int k = 0; k < COLS; k++) begin
      if (pins_q[k]) press_col = CW'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    pins_d       = pins;
    pins_prev_d  = pins_q;
    col_d        = col_q;
    row_d        = row_q;
    target_d     = target_q;
    tick_d       = tick_q;
    anim_valid_d = anim_valid_q;
    reject_d     = 1'b0;
    player_d     = player_q;
    move_count_d = move_count_q;
    board_d      = board_q;
    height_d     = height_q;

    case (state_q)
      IDLE: begin
        if (press_evt) begin
          if (height_q[press_col] == FULL_H) begin
            reject_d = 1'b1;
          end else begin
            target_d     = RW'(height_q[press_col]);
            col_d        = press_col;
            row_d        = TOP_ROW;
            anim_valid_d = 1'b1;
            tick_d       = '0;
            state_d      = DROP;
          end
        end
      end
      DROP: begin
        if (tick_q == LAST_TICK) begin
          if (row_q == target_q) begin
            state_d = COMMIT;
          end else begin
            row_d  = row_q - RW'(1);
            tick_d = '0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      COMMIT: begin
        board_d[col_q][target_q] = player_q ? 2'b10 : 2'b01;
        height_d[col_q]          = height_q[col_q] + HW'(1);
        move_count_d             = move_count_q + MW'(1);
        player_d                 = ~player_q;
        anim_valid_d             = 1'b0;
        state_d                  = (move_count_d == MAX_MOVES) ? OVER : IDLE;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pins_q       <= '0;
      pins_prev_q  <= '0;
      col_q        <= '0;
      row_q        <= '0;
      target_q     <= '0;
      tick_q       <= '0;
      anim_valid_q <= 1'b0;
      reject_q     <= 1'b0;
      player_q     <= 1'b0;
      move_count_q <= '0;
      board_q      <= '{default: '{default: 2'b00}};
      height_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pins_q       <= pins_d;
      pins_prev_q  <= pins_prev_d;
      col_q        <= col_d;
      row_q        <= row_d;
      target_q     <= target_d;
      tick_q       <= tick_d;
      anim_valid_q <= anim_valid_d;
      reject_q     <= reject_d;
      player_q     <= player_d;
      move_count_q <= move_count_d;
      board_q      <= board_d;
      height_q     <= height_d;
    end
  end

  // Scan read port: combinational, addresses beyond the board read as empty.
  always_comb begin
    rd_cell = 2'b00;
    if ((int'(rd_col) < COLS) && (int'(rd_row) < ROWS)) begin
      rd_cell = board_q[rd_col][rd_row];
    end
  end

  assign anim_valid = anim_valid_q;
  assign anim_col   = col_q;
  assign anim_row   = row_q;
  assign player     = player_q;
  assign busy       = (state_q == DROP) || (state_q == COMMIT);
  assign reject     = reject_q;
  assign move_count = move_count_q;
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer: reset, first drop timing, full column,
// held/multi-hot/busy presses, full board, reset in the middle of a drop.
module tb_drop_sequencer;

  logic       clk;
  logic       rst_n;
  logic [6:0] pins;
  logic [2:0] rd_col;
  logic [2:0] rd_row;
  logic [1:0] rd_cell;
  logic       anim_valid;
  logic [2:0] anim_col;
  logic [2:0] anim_row;
  logic       player;
  logic       busy;
  logic       reject;
  logic [5:0] move_count;
  logic       game_over;

  int vectors;
  int miscompares;

  drop_sequencer #(.COLS(7), .ROWS(6), .DROP_TICKS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pins      (pins),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_cell   (rd_cell),
    .anim_valid(anim_valid),
    .anim_col  (anim_col),
    .anim_row  (anim_row),
    .player    (player),
    .busy      (busy),
    .reject    (reject),
    .move_count(move_count),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int c, input int r, output logic [1:0] v);
    rd_col = 3'(c);
    rd_row = 3'(r);
    #1;
    v = rd_cell;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pins  = '0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // One legal move into column c whose current height is t; ends 1 ns after
  // the COMMIT edge: 2 cycles of sampling + (6-t)*4 DROP + 1 COMMIT.
  task automatic do_move(input int c, input int t);
    logic [6:0] p;
    p = '0;
    p[c] = 1'b1;
    pins = p;
    cyc(1);
    pins = '0;
    cyc((6 - t) * 4 + 2);
  endtask

  task automatic test_reset();
    logic [1:0] v;
    do_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (anim_valid !== 1'b0) begin miscompares++; $display("FAIL reset_anim_valid got %b want 0", anim_valid); end
    vectors++; if (anim_col !== 3'd0 || anim_row !== 3'd0) begin miscompares++; $display("FAIL reset_anim_pos got %0d,%0d want 0,0", anim_col, anim_row); end
    vectors++; if (player !== 1'b0) begin miscompares++; $display("FAIL reset_player got %b want 0", player); end
    vectors++; if (reject !== 1'b0) begin miscompares++; $display("FAIL reset_reject got %b want 0", reject); end
    vectors++; if (move_count !== 6'd0) begin miscompares++; $display("FAIL reset_move_count got %0d want 0", move_count); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over got %b want 0", game_over); end
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        read_cell(c, r, v);
        vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL reset_cell(%0d,%0d) got %b want 00", c, r, v); end
      end
    end
    cyc(1);
  endtask

  task automatic test_first_drop();
    logic [1:0] v;
    do_reset();
    pins = 7'b0001000;
    cyc(1);
    pins = '0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_early_busy got %b want 0", busy); end
    cyc(1);
    vectors++; if (busy !== 1'b1 || anim_valid !== 1'b1) begin miscompares++; $display("FAIL drop_entry busy/valid got %b%b want 11", busy, anim_valid); end
    vectors++; if (anim_col !== 3'd3) begin miscompares++; $display("FAIL drop_anim_col got %0d want 3", anim_col); end
    for (int k = 0; k < 6; k++) begin
      vectors++; if (anim_row !== 3'(5 - k)) begin miscompares++; $display("FAIL drop_row_start k=%0d got %0d want %0d", k, anim_row, 5 - k); end
      cyc(3);
      vectors++; if (anim_row !== 3'(5 - k)) begin miscompares++; $display("FAIL drop_row_end k=%0d got %0d want %0d", k, anim_row, 5 - k); end
      cyc(1);
    end
    // 24 cycles after entry: COMMIT, board not yet written
    read_cell(3, 0, v);
    vectors++; if (busy !== 1'b1 || v !== 2'b00) begin miscompares++; $display("FAIL drop_commit_cycle busy=%b cell=%b want 1,00", busy, v); end
    cyc(1);
    read_cell(3, 0, v);
    vectors++; if (v !== 2'b01) begin miscompares++; $display("FAIL drop_cell(3,0) got %b want 01", v); end
    read_cell(2, 0, v);
    vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL drop_cell(2,0) got %b want 00", v); end
    vectors++; if (player !== 1'b1 || move_count !== 6'd1) begin miscompares++; $display("FAIL drop_after player=%b count=%0d want 1,1", player, move_count); end
    vectors++; if (busy !== 1'b0 || anim_valid !== 1'b0) begin miscompares++; $display("FAIL drop_after busy/valid got %b%b want 00", busy, anim_valid); end
    cyc(1);
  endtask

  task automatic test_full_column();
    logic [1:0] v;
    logic [1:0] exp_c;
    do_reset();
    for (int t = 0; t < 6; t++) do_move(0, t);
    for (int r = 0; r < 6; r++) begin
      exp_c = (r % 2 == 0) ? 2'b01 : 2'b10;
      read_cell(0, r, v);
      vectors++; if (v !== exp_c) begin miscompares++; $display("FAIL column_cell(0,%0d) got %b want %b", r, v, exp_c); end
    end
    cyc(1);
    pins = 7'b0000001;
    cyc(1);
    pins = '0;
    vectors++; if (reject !== 1'b0) begin miscompares++; $display("FAIL reject_early got %b want 0", reject); end
    cyc(1);
    vectors++; if (reject !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL reject_pulse reject=%b busy=%b want 1,0", reject, busy); end
    cyc(1);
    vectors++; if (reject !== 1'b0) begin miscompares++; $display("FAIL reject_width got %b want 0", reject); end
    cyc(3);
    vectors++; if (move_count !== 6'd6 || busy !== 1'b0) begin miscompares++; $display("FAIL reject_state count=%0d busy=%b want 6,0", move_count, busy); end
  endtask

  task automatic test_held();
    logic [1:0] v;
    do_reset();
    pins = 7'b0000001;
    cyc(100);
    pins = '0;
    cyc(5);
    vectors++; if (move_count !== 6'd1) begin miscompares++; $display("FAIL held_count got %0d want 1", move_count); end
    read_cell(0, 1, v);
    vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL held_cell(0,1) got %b want 00", v); end
    cyc(1);
  endtask

  task automatic test_multihot();
    int bad;
    bad = 0;
    pins = 7'b0000011;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (busy !== 1'b0 || reject !== 1'b0) bad++;
    end
    pins = '0;
    cyc(3);
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL multihot_activity got %0d busy/reject cycles want 0", bad); end
    vectors++; if (move_count !== 6'd1) begin miscompares++; $display("FAIL multihot_count got %0d want 1", move_count); end
  endtask

  task automatic test_busy_press();
    logic [1:0] v;
    pins = 7'b0000100;
    cyc(1);
    pins = '0;
    cyc(5);
    pins = 7'b0100000;
    cyc(1);
    pins = '0;
    cyc(20);
    vectors++; if (move_count !== 6'd2 || player !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL busy_press count=%0d player=%b busy=%b want 2,0,0", move_count, player, busy); end
    read_cell(2, 0, v);
    vectors++; if (v !== 2'b10) begin miscompares++; $display("FAIL busy_press_cell(2,0) got %b want 10", v); end
    read_cell(5, 0, v);
    vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL busy_press_cell(5,0) got %b want 00", v); end
    cyc(10);
    vectors++; if (move_count !== 6'd2) begin miscompares++; $display("FAIL busy_press_late got %0d want 2", move_count); end
  endtask

  task automatic test_board_full();
    logic [1:0] v;
    logic [1:0] exp_c;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        do_move(c, r);
        if (c * 6 + r == 40) begin
          vectors++; if (game_over !== 1'b0 || move_count !== 6'd41) begin miscompares++; $display("FAIL full_41 game_over=%b count=%0d want 0,41", game_over, move_count); end
        end
      end
    end
    vectors++; if (game_over !== 1'b1 || move_count !== 6'd42) begin miscompares++; $display("FAIL full_42 game_over=%b count=%0d want 1,42", game_over, move_count); end
    vectors++; if (busy !== 1'b0 || player !== 1'b0) begin miscompares++; $display("FAIL full_state busy=%b player=%b want 0,0", busy, player); end
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        exp_c = (r % 2 == 0) ? 2'b01 : 2'b10;
        read_cell(c, r, v);
        vectors++; if (v !== exp_c) begin miscompares++; $display("FAIL full_cell(%0d,%0d) got %b want %b", c, r, v, exp_c); end
      end
    end
    read_cell(7, 0, v);
    vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL cell_col_oob got %b want 00", v); end
    read_cell(0, 6, v);
    vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL cell_row_oob got %b want 00", v); end
    cyc(1);
  endtask

  task automatic test_over_ignore();
    int bad;
    bad = 0;
    pins = 7'b0001000;
    cyc(1);
    pins = '0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (busy !== 1'b0 || reject !== 1'b0 || anim_valid !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL over_activity got %0d active cycles want 0", bad); end
    vectors++; if (move_count !== 6'd42 || game_over !== 1'b1) begin miscompares++; $display("FAIL over_state count=%0d game_over=%b want 42,1", move_count, game_over); end
  endtask

  task automatic test_reset_mid_drop();
    logic [1:0] v;
    do_reset();
    do_move(4, 0);
    pins = 7'b0000010;
    cyc(1);
    pins = '0;
    cyc(9);
    vectors++; if (anim_row !== 3'd3 || anim_valid !== 1'b1) begin miscompares++; $display("FAIL middrop_pre row=%0d valid=%b want 3,1", anim_row, anim_valid); end
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    vectors++; if (anim_valid !== 1'b0 || player !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL middrop_post valid=%b player=%b busy=%b want 0,0,0", anim_valid, player, busy); end
    vectors++; if (move_count !== 6'd0) begin miscompares++; $display("FAIL middrop_count got %0d want 0", move_count); end
    read_cell(4, 0, v);
    vectors++; if (v !== 2'b00) begin miscompares++; $display("FAIL middrop_cell(4,0) got %b want 00", v); end
    cyc(30);
    read_cell(1, 0, v);
    vectors++; if (v !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL middrop_late cell=%b busy=%b want 00,0", v, busy); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    pins   = '0;
    rd_col = '0;
    rd_row = '0;
    #1;
    test_reset();
    test_first_drop();
    test_full_column();
    test_held();
    test_multihot();
    test_busy_press();
    test_board_full();
    test_over_ignore();
    test_reset_mid_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
